// File: rtl/wizard_core.sv
// wizardCore: single-cycle RV32I-subset CPU with internal instruction ROM and data RAM.
// Each non-reset rising edge commits one instruction; the last committed store is exposed.
module wizard_core_top #(
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // The ROM image is placed into imem by the surrounding environment before reset is released.
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] regs [32];
  logic [31:0] pc;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] eff_addr;
  logic [31:0] load_data;
  logic [31:0] wb_data;
  logic [31:0] next_pc;
  logic        reg_we;
  logic        mem_we;

  assign instr  = imem[pc[IW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // x0 is forced to zero on read, so its storage never matters.
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

  assign eff_addr  = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign load_data = dmem[eff_addr[DW+1:2]];

  always_comb begin
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wb_data = 32'h0;
    next_pc = pc + 32'd4;
    case (opcode)
      OP_LUI: begin
        reg_we  = 1'b1;
        wb_data = imm_u;
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          reg_we  = 1'b1;
          wb_data = rs1_val + imm_i;
        end
      end
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          reg_we = 1'b1;
          case (funct3)
            3'b000:  wb_data = rs1_val + rs2_val;
            3'b111:  wb_data = rs1_val & rs2_val;
            3'b110:  wb_data = rs1_val | rs2_val;
            3'b100:  wb_data = rs1_val ^ rs2_val;
            3'b010:  wb_data = {31'h0, $signed(rs1_val) < $signed(rs2_val)};
            default: reg_we  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          reg_we  = 1'b1;
          wb_data = rs1_val - rs2_val;
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_we  = 1'b1;
          wb_data = load_data;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) mem_we = 1'b1;
      end
      OP_BRANCH: begin
        if ((funct3 == 3'b000 && rs1_val == rs2_val) ||
            (funct3 == 3'b001 && rs1_val != rs2_val)) begin
          next_pc = pc + imm_b;
        end
      end
      OP_JAL: begin
        reg_we  = 1'b1;
        wb_data = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc       <= RESET_PC;
      mem_addr <= 32'h0;
      mem_data <= 32'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else begin
      pc <= next_pc;
      if (reg_we && rd != 5'd0) regs[rd] <= wb_data;
      if (mem_we) begin
        mem_addr <= eff_addr;
        mem_data <= rs2_val;
      end
    end
  end

  // Data RAM keeps its contents through reset; reset only suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset_n && mem_we) dmem[eff_addr[DW+1:2]] <= rs2_val;
  end

endmodule

// File: tb/tb_wizard_core_top.sv
// Bench for wizard_core_top: directed programs with fixed expectations, plus random
// programs checked cycle by cycle against an instruction-level model.
module tb_wizard_core_top;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] prog_q [$];
  logic [31:0] rom [256];
  logic [63:0] exp_q [$];

  logic [31:0] m_x [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  logic [31:0] m_data;

  wizard_core_top #(
    .IMEM_WORDS(256),
    .DMEM_WORDS(256),
    .RESET_PC  (32'h0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mem_addr(mem_addr),
    .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(int op, int rd, int f3, int rs1, int imm);
    logic [31:0] o, d, f, s, m;
    o = op; d = rd; f = f3; s = rs1; m = imm;
    return {m[11:0], s[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int f3, int rd, int rs1, int rs2);
    logic [31:0] g, f, d, s, t;
    g = f7; f = f3; d = rd; s = rs1; t = rs2;
    return {g[6:0], t[4:0], s[4:0], f[2:0], d[4:0], 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(int f3, int rs2, int rs1, int imm);
    logic [31:0] f, t, s, m;
    f = f3; t = rs2; s = rs1; m = imm;
    return {m[11:5], t[4:0], s[4:0], f[2:0], m[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int imm);
    logic [31:0] f, t, s, m;
    f = f3; t = rs2; s = rs1; m = imm;
    return {m[12], m[10:5], t[4:0], s[4:0], f[2:0], m[4:1], m[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(int rd, logic [31:0] v);
    logic [31:0] d;
    d = rd;
    return {v[31:12], d[4:0], 7'h37};
  endfunction

  function automatic logic [31:0] enc_j(int rd, int imm);
    logic [31:0] d, m;
    d = rd; m = imm;
    return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'h6f};
  endfunction

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i('h13, rd, 0, rs1, imm);
  endfunction
  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    return enc_i('h03, rd, 2, rs1, imm);
  endfunction
  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    return enc_s(2, rs2, rs1, imm);
  endfunction

  // ---------------- reference model (ISA level) ----------------
  function automatic void model_reset();
    m_pc   = 32'h0;
    m_addr = 32'h0;
    m_data = 32'h0;
    for (int i = 0; i < 32; i++) m_x[i] = 32'h0;
  endfunction

  function automatic void model_step();
    logic [31:0] ins, a, b, ea, res, npc;
    logic [31:0] ii, is, ib, ij;
    logic [6:0]  op, f7;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        wr;
    ins = rom[m_pc[9:2]];
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = m_x[ins[19:15]];
    b   = m_x[ins[24:20]];
    ii  = {{20{ins[31]}}, ins[31:20]};
    is  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    npc = m_pc + 4;
    wr  = 1'b0;
    res = 32'h0;
    if (op == 7'h37) begin
      wr = 1'b1; res = {ins[31:12], 12'h000};
    end else if (op == 7'h13 && f3 == 3'd0) begin
      wr = 1'b1; res = a + ii;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) begin
      wr = 1'b1; res = a + b;
    end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
      wr = 1'b1; res = a - b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) begin
      wr = 1'b1; res = a & b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) begin
      wr = 1'b1; res = a | b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) begin
      wr = 1'b1; res = a ^ b;
    end else if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd2) begin
      wr = 1'b1; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end else if (op == 7'h03 && f3 == 3'd2) begin
      ea = a + ii; wr = 1'b1; res = m_mem[ea[9:2]];
    end else if (op == 7'h23 && f3 == 3'd2) begin
      ea = a + is; m_mem[ea[9:2]] = b; m_addr = ea; m_data = b;
    end else if (op == 7'h63 && ((f3 == 3'd0 && a == b) || (f3 == 3'd1 && a != b))) begin
      npc = m_pc + ib;
    end else if (op == 7'h6f) begin
      wr = 1'b1; res = m_pc + 4; npc = m_pc + ij;
    end
    if (wr && rd != 5'd0) m_x[rd] = res;
    m_pc = npc;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (reset_n) model_reset();
      else model_step();
    end
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) begin
      rom[i] = (i < prog_q.size()) ? prog_q[i] : 32'h0;
      dut.imem[i] = rom[i];
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b1;
    tick(2);
    reset_n = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    prog_q.delete();
    prog_q.push_back(addi(1, 0, 5));
    prog_q.push_back(addi(2, 0, 'h40));
    prog_q.push_back(sw(1, 2, 0));
    prog_q.push_back(enc_j(0, 0));
    load_prog();
    do_reset();
    total++;
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %08h want %08h", mem_addr, 32'h0); end
    total++;
    if (mem_data !== 32'h0) begin bad++; $display("FAIL reset_data: got %08h want %08h", mem_data, 32'h0); end
  endtask

  task automatic test_store_basic();
    tick(3);
    total++;
    if (mem_addr !== 32'h40) begin bad++; $display("FAIL sw_addr: got %08h want %08h", mem_addr, 32'h40); end
    total++;
    if (mem_data !== 32'h5) begin bad++; $display("FAIL sw_data: got %08h want %08h", mem_data, 32'h5); end
    tick(2);
    total++;
    if (mem_addr !== 32'h40) begin bad++; $display("FAIL hold_addr: got %08h want %08h", mem_addr, 32'h40); end
    total++;
    if (mem_data !== 32'h5) begin bad++; $display("FAIL hold_data: got %08h want %08h", mem_data, 32'h5); end
  endtask

  task automatic test_lui_wrap();
    prog_q.delete();
    prog_q.push_back(enc_u(1, 32'h80000000));
    prog_q.push_back(addi(2, 1, -1));
    prog_q.push_back(sw(2, 0, 'h10));
    prog_q.push_back(enc_j(0, 0));
    load_prog();
    do_reset();
    tick(3);
    total++;
    if (mem_addr !== 32'h10) begin bad++; $display("FAIL wrap_addr: got %08h want %08h", mem_addr, 32'h10); end
    total++;
    if (mem_data !== 32'h7FFFFFFF) begin bad++; $display("FAIL wrap_data: got %08h want %08h", mem_data, 32'h7FFFFFFF); end
  endtask

  task automatic test_load_after_store();
    prog_q.delete();
    prog_q.push_back(addi(1, 0, 'hAB));
    prog_q.push_back(sw(1, 0, 'h20));
    prog_q.push_back(lw(3, 0, 'h20));
    prog_q.push_back(addi(3, 3, 1));
    prog_q.push_back(sw(3, 0, 'h24));
    prog_q.push_back(enc_j(0, 0));
    load_prog();
    do_reset();
    tick(2);
    total++;
    if (mem_addr !== 32'h20) begin bad++; $display("FAIL st1_addr: got %08h want %08h", mem_addr, 32'h20); end
    total++;
    if (mem_data !== 32'hAB) begin bad++; $display("FAIL st1_data: got %08h want %08h", mem_data, 32'hAB); end
    tick(3);
    total++;
    if (mem_addr !== 32'h24) begin bad++; $display("FAIL ld_st_addr: got %08h want %08h", mem_addr, 32'h24); end
    total++;
    if (mem_data !== 32'hAC) begin bad++; $display("FAIL ld_st_data: got %08h want %08h", mem_data, 32'hAC); end
  endtask

  task automatic test_loop_x0();
    prog_q.delete();
    prog_q.push_back(addi(1, 0, 0));
    prog_q.push_back(addi(2, 0, 3));
    prog_q.push_back(addi(1, 1, 1));
    prog_q.push_back(enc_b(1, 1, 2, -4));
    prog_q.push_back(sw(1, 0, 0));
    prog_q.push_back(addi(0, 0, 7));
    prog_q.push_back(sw(0, 0, 8));
    prog_q.push_back(enc_j(0, 0));
    load_prog();
    do_reset();
    tick(9);
    total++;
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL loop_addr: got %08h want %08h", mem_addr, 32'h0); end
    total++;
    if (mem_data !== 32'h3) begin bad++; $display("FAIL loop_data: got %08h want %08h", mem_data, 32'h3); end
    tick(2);
    total++;
    if (mem_addr !== 32'h8) begin bad++; $display("FAIL x0_addr: got %08h want %08h", mem_addr, 32'h8); end
    total++;
    if (mem_data !== 32'h0) begin bad++; $display("FAIL x0_data: got %08h want %08h", mem_data, 32'h0); end
  endtask

  task automatic gen_random_prog();
    int rd, r1, r2, sel, imm, base;
    prog_q.delete();
    prog_q.push_back(enc_u(31, 32'h00001000));
    for (int k = 0; k < 16; k++) prog_q.push_back(sw(0, 0, k * 4));
    for (int i = 0; i < 60; i++) begin
      rd   = int'($urandom_range(0, 7));
      r1   = int'($urandom_range(0, 7));
      r2   = int'($urandom_range(0, 7));
      imm  = int'($urandom_range(0, 4095)) - 2048;
      base = ($urandom_range(0, 1) == 1) ? 31 : 0;
      sel  = int'($urandom_range(0, 10));
      case (sel)
        0: prog_q.push_back(enc_u(rd, $urandom()));
        1, 2: prog_q.push_back(addi(rd, r1, imm));
        3, 4: begin
          case ($urandom_range(0, 5))
            0: prog_q.push_back(enc_r('h00, 0, rd, r1, r2));
            1: prog_q.push_back(enc_r('h20, 0, rd, r1, r2));
            2: prog_q.push_back(enc_r('h00, 7, rd, r1, r2));
            3: prog_q.push_back(enc_r('h00, 6, rd, r1, r2));
            4: prog_q.push_back(enc_r('h00, 4, rd, r1, r2));
            default: prog_q.push_back(enc_r('h00, 2, rd, r1, r2));
          endcase
        end
        5: prog_q.push_back(lw(rd, base, 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3))));
        6: prog_q.push_back(sw(r2, base, 4 * int'($urandom_range(0, 15)) + int'($urandom_range(0, 3))));
        7: prog_q.push_back(enc_b(int'($urandom_range(0, 1)), r1, r2, 4 * int'($urandom_range(2, 3))));
        8: prog_q.push_back(enc_j(rd, 8));
        default: begin
          case ($urandom_range(0, 4))
            0: prog_q.push_back(enc_i('h13, rd, 1, r1, 3));
            1: prog_q.push_back(enc_r('h01, 0, rd, r1, r2));
            2: prog_q.push_back(enc_i('h0b, rd, 0, r1, imm));
            3: prog_q.push_back(enc_s(0, r2, 0, 4));
            default: prog_q.push_back(enc_i('h03, rd, 0, 0, 8));
          endcase
        end
      endcase
    end
    for (int k = 1; k < 8; k++) prog_q.push_back(sw(k, 0, k * 4));
    prog_q.push_back(enc_j(0, 0));
  endtask

  task automatic test_random(input int rounds);
    logic [63:0] e;
    for (int r = 0; r < rounds; r++) begin
      gen_random_prog();
      load_prog();
      do_reset();
      for (int c = 0; c < 100; c++) begin
        tick(1);
        exp_q.push_back({m_addr, m_data});
        e = exp_q.pop_front();
        total++;
        if (mem_addr !== e[63:32]) begin
          bad++;
          $display("FAIL rand_addr r%0d c%0d: got %08h want %08h", r, c, mem_addr, e[63:32]);
        end
        total++;
        if (mem_data !== e[31:0]) begin
          bad++;
          $display("FAIL rand_data r%0d c%0d: got %08h want %08h", r, c, mem_data, e[31:0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] keep;
    prog_q.delete();
    prog_q.push_back(addi(1, 0, 'h55));
    prog_q.push_back(addi(2, 0, 'h66));
    prog_q.push_back(sw(2, 0, 'h34));
    prog_q.push_back(sw(1, 0, 'h30));
    prog_q.push_back(enc_j(0, 0));
    load_prog();
    do_reset();
    tick(3);
    total++;
    if (mem_addr !== 32'h34) begin bad++; $display("FAIL pre_addr: got %08h want %08h", mem_addr, 32'h34); end
    total++;
    if (mem_data !== 32'h66) begin bad++; $display("FAIL pre_data: got %08h want %08h", mem_data, 32'h66); end
    keep = m_mem[12];
    reset_n = 1'b1;
    tick(1);
    total++;
    if (mem_addr !== 32'h0) begin bad++; $display("FAIL midrst_addr: got %08h want %08h", mem_addr, 32'h0); end
    total++;
    if (mem_data !== 32'h0) begin bad++; $display("FAIL midrst_data: got %08h want %08h", mem_data, 32'h0); end
    total++;
    if (dut.dmem[12] !== keep) begin bad++; $display("FAIL midrst_dmem: got %08h want %08h", dut.dmem[12], keep); end
    reset_n = 1'b0;
    tick(4);
    total++;
    if (mem_addr !== 32'h30) begin bad++; $display("FAIL restart_addr: got %08h want %08h", mem_addr, 32'h30); end
    total++;
    if (mem_data !== 32'h55) begin bad++; $display("FAIL restart_data: got %08h want %08h", mem_data, 32'h55); end
    total++;
    if (dut.dmem[12] !== 32'h55) begin bad++; $display("FAIL restart_dmem: got %08h want %08h", dut.dmem[12], 32'h55); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
    model_reset();
    test_reset();
    test_store_basic();
    test_lui_wrap();
    test_load_after_store();
    test_loop_x0();
    test_random(4);
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
